data_mem_responder: RTL and testbench

Data-memory responder for the RV64I core: the target side of the load/store request the control path issues (mem read/write enable, size 8/16/32/64, unsigned-load flag). It accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles to emulate memory latency, performs the access on a little-endian 64-bit-word array, and returns sign- or zero-extended load data with an error flag. It lets the team exercise the core's data path against a memory with multi-cycle latency instead of an ideal one-cycle array.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the core's data path
// (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed emulated latency,
// little-endian 64-bit word array, sign/zero-extended load data plus error flag.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] BYTE_CAP = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_unsigned;

  logic [63:0] mem [DEPTH_WORDS];

  logic             accept, commit, err, mem_we;
  logic             op_write, op_unsigned, misaligned;
  logic [63:0]      op_addr, op_wdata;
  logic [1:0]       op_size;
  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic [63:0]      rd_word, shifted, load_data, wdata_lane, rdata_nxt;
  logic [7:0]       be;

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;
  // With LATENCY=1 the commit edge is the acceptance edge, so operands come
  // straight from the request bus instead of the latched copy.
  assign commit = (state == WAIT && cnt == 4'd0) || (accept && LATENCY == 1);

  // NOTE: every signal written here gets a default first, otherwise paths that
  // skip an assignment infer latches.
  always_comb begin
    op_write    = lat_write;
    op_addr     = lat_addr;
    op_wdata    = lat_wdata;
    op_size     = lat_size;
    op_unsigned = lat_unsigned;
    if (state == IDLE) begin
      op_write    = bus.req_write;
      op_addr     = bus.req_addr;
      op_wdata    = bus.req_wdata;
      op_size     = bus.req_size;
      op_unsigned = bus.req_unsigned;
    end

    case (op_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = op_addr[0];
      2'd2:    misaligned = |op_addr[1:0];
      default: misaligned = |op_addr[2:0];
    endcase
    err = misaligned || (op_addr >= BYTE_CAP);

    idx     = op_addr[IDX_W+2:3];
    off     = op_addr[2:0];
    rd_word = mem[idx];
    shifted = rd_word >> {off, 3'b000};

    case (op_size)
      2'd0:    load_data = op_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_data = op_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = op_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = rd_word;
    endcase

    case (op_size)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be         = be << off;
    wdata_lane = op_wdata << {off, 3'b000};

    rdata_nxt = (err || op_write) ? 64'd0 : load_data;
    // Reset on the commit edge suppresses the store.
    mem_we    = commit && rst_n && op_write && !err;
  end

  // NOTE: the array has no reset; contents survive rst_n so it maps onto RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (mem_we && be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 64'd0;
      bus.rsp_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write     <= bus.req_write;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            lat_size      <= bus.req_size;
            lat_unsigned  <= bus.req_unsigned;
            cnt           <= CNT_INIT;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (commit) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= rdata_nxt;
              bus.rsp_error <= err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (commit) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rdata_nxt;
            bus.rsp_error <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 64'd0;
            bus.rsp_error <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed load/store cases plus
// randomized traffic checked against a byte-array reference model.
module tb_data_mem_responder;

  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;
  localparam logic [63:0] BYTES = 64'(DEPTH) * 64'd8;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc;
  int   ready_mode = 1;  // 0 hold low, 1 hold high, 2 random
  bit   count_busy = 0;
  int   busy_cyc   = 0;
  exp_t sb[$];
  logic [7:0] mem_m [DEPTH*8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: byte-addressed array, access applied at acceptance.
  function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] wd,
                                input logic [1:0] sz, input logic uns,
                                output logic [63:0] rd, output logic er);
    int nb = 1 << sz;
    er = ((a % 64'(nb)) != 0) || (a >= BYTES);
    rd = '0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < nb; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = mem_m[int'(a) + i];
      if (!uns && nb < 8 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
    end
  endfunction

  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic uns,
                       input bit has_k = 0, input logic [63:0] k_rd = '0, input logic k_er = 1'b0);
    exp_t e;
    logic [63:0] m_rd;
    logic m_er;
    bit ok = 0;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail_now("req_ready_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    model(w, a, wd, sz, uns, m_rd, m_er);
    e.rdata  = has_k ? k_rd : m_rd;
    e.err    = has_k ? k_er : m_er;
    e.acc    = cyc + 1;
    last_acc = e.acc;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency, hold-while-stalled and response contents.
  logic        prev_v = 1'b0;
  logic [63:0] held_rd;
  logic        held_er;
  always @(negedge clk) begin
    if (count_busy && busy) busy_cyc++;
    if (bus.rsp_valid) begin
      if (!prev_v) begin
        held_rd = bus.rsp_rdata;
        held_er = bus.rsp_error;
        if (sb.size() == 0) fail_now("unexpected_rsp");
        else check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
      end else begin
        check("hold_rdata", bus.rsp_rdata, held_rd);
        check("hold_error", 64'(bus.rsp_error), 64'(held_er));
        check("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
      end
      if (bus.rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_error", 64'(bus.rsp_error), 64'(e.err));
      end
    end
    prev_v = bus.rsp_valid;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 64'd0);
    check({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'd0);
    check({tag, "_busy"},      64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_acc;
    bit          seen;
    logic [1:0]  sz;
    logic [63:0] a;
    int          nb;

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Give the region used below known contents.
    for (int w = 0; w < 64; w++) issue(1'b1, 64'(w * 8), 64'd0, 2'd3, 1'b0);
    issue(1'b1, BYTES - 64'd8, 64'd0, 2'd3, 1'b0);
    drain();

    // Double store/load, byte lanes and extension.
    issue(1'b1, 64'h40, 64'h1122334455667788, 2'd3, 1'b0, 1, 64'd0, 1'b0);
    issue(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, 1, 64'h1122334455667788, 1'b0);
    issue(1'b0, 64'h47, 64'd0, 2'd0, 1'b0, 1, 64'h0000000000000011, 1'b0);
    issue(1'b1, 64'h41, 64'h80, 2'd0, 1'b0, 1, 64'd0, 1'b0);
    issue(1'b0, 64'h41, 64'd0, 2'd0, 1'b0, 1, 64'hFFFFFFFFFFFFFF80, 1'b0);
    issue(1'b0, 64'h41, 64'd0, 2'd0, 1'b1, 1, 64'h0000000000000080, 1'b0);
    issue(1'b0, 64'h40, 64'd0, 2'd3, 1'b1, 1, 64'h1122334455668088, 1'b0);
    issue(1'b1, 64'h104, 64'h8000ABCD, 2'd2, 1'b0, 1, 64'd0, 1'b0);
    issue(1'b0, 64'h104, 64'd0, 2'd2, 1'b0, 1, 64'hFFFFFFFF8000ABCD, 1'b0);
    issue(1'b0, 64'h106, 64'd0, 2'd1, 1'b1, 1, 64'h0000000000008000, 1'b0);

    // Misaligned and out-of-range accesses leave the array untouched.
    issue(1'b0, 64'h41, 64'd0, 2'd1, 1'b0, 1, 64'd0, 1'b1);
    issue(1'b1, BYTES, 64'hDEADBEEFCAFEF00D, 2'd3, 1'b0, 1, 64'd0, 1'b1);
    issue(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, 1, 64'h1122334455668088, 1'b0);
    issue(1'b0, BYTES - 64'd8, 64'd0, 2'd3, 1'b0, 1, 64'd0, 1'b0);
    drain();

    // Backpressure: response held for 5 cycles with rsp_ready low.
    ready_mode = 0;
    @(posedge clk);
    #1;
    issue(1'b0, 64'h104, 64'd0, 2'd3, 1'b0);
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("bp_rsp_valid_timeout");
    repeat (5) @(negedge clk);
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 ready_mode = 1;
    drain();

    // Reset on the commit edge of a store to 0x80 aborts it.
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h80;
    bus.req_wdata = 64'hAAAA5555AAAA5555;
    bus.req_size  = 2'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_wait", 64'(busy), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    issue(1'b0, 64'h80, 64'd0, 2'd3, 1'b0, 1, 64'd0, 1'b0);
    drain();

    // Back-to-back loads: each request keeps the FSM busy for LATENCY+1
    // cycles, with one idle req_ready cycle before the next acceptance.
    busy_cyc   = 0;
    count_busy = 1;
    issue(1'b0, 64'h40, 64'd0, 2'd3, 1'b0);
    first_acc = last_acc;
    issue(1'b0, 64'h104, 64'd0, 2'd2, 1'b1);
    issue(1'b0, 64'h47, 64'd0, 2'd0, 1'b0);
    issue(1'b0, 64'h106, 64'd0, 2'd1, 1'b0);
    drain();
    count_busy = 0;
    check("tput_busy_cycles", 64'(busy_cyc), 64'(4 * (LAT + 1)));
    check("tput_accept_span", 64'(last_acc - first_acc), 64'(3 * (LAT + 2)));

    // Randomized traffic, including misaligned and out-of-range addresses.
    ready_mode = 2;
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = 64'($urandom_range(0, 511)) & ~64'(nb - 1);
      case ($urandom_range(0, 9))
        0:       a = a | 64'd1;
        1:       a = BYTES + a;
        2:       a = {$urandom, $urandom} & ~64'(nb - 1);
        default: ;
      endcase
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1 ready_mode = 1;
    drain();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
